count_toggle_monitor: RTL and testbench
=======================================

// Module: count_toggle_monitor
// PURPOSE
//  Receive-side checker for the 4-bit counter/toggle interface driven by the counter block.
//  Samples count and t every clock, locks onto the sequence, then flags skipped counts and bad t toggles.
//  Keeps saturating error/wrap statistics; synthesizable companion to the bound assertion checker.
// PARAMETERS
//  LOCK_CYCLES  4  consecutive good steps needed to declare lock (1..15)
//  ERR_W        8  width of err_cnt (saturating)
//  WRAP_W       8  width of wrap_cnt (free-running, wraps)
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  rst_n     in   1       async active-low reset
//  enable    in   1       1 = monitor active; 0 = return to IDLE, stats held
//  count     in   4       observed counter value
//  t         in   1       observed toggle bit
//  err_clr   in   1       sync clear of err_cnt and err_sticky
//  locked    out  1       1 while state == LOCKED
//  err_pulse out  1       one-cycle pulse per detected violation
//  err_code  out  2       01 count skip, 10 toggle error, 11 both; valid with err_pulse, else 00
//  err_sticky out 1       set on any violation until err_clr
//  err_cnt   out  ERR_W   violations since clear, saturates at all-ones
//  wrap_cnt  out  WRAP_W  15->0 wraps seen while LOCKED, modulo 2^WRAP_W
// BEHAVIOUR
//  Interface rule: step is good iff count == prev_count+1 (mod 16) AND t == prev_t ^ (prev_count==15).
//  rst_n low: state IDLE, prev regs 0, run 0, all outputs 0. Async assert, sync deassert via clk.
//  States: IDLE -> SYNC -> LOCKED; any bad step in LOCKED -> SYNC.
//   IDLE: when enable=1, capture count/t into prev regs, goto SYNC with run=0 (no check this cycle).
//   SYNC: good step -> run++; bad step -> run=0 (no error reported). run reaching LOCK_CYCLES -> LOCKED.
//   LOCKED: good step: no action; if prev_count==15 also wrap_cnt++.
//           bad step: err_pulse=1, err_code per rule, err_sticky=1, err_cnt++ (sat), goto SYNC, run=0.
//  prev_count/prev_t update every cycle in SYNC/LOCKED with current sample (also after a bad step).
//  Latency: all outputs registered; err_pulse/err_code/locked reflect sample of previous edge (1 cycle).
//  locked rises the cycle after the LOCK_CYCLES-th good step; falls the cycle err_pulse asserts.
//  enable low (any state): next state IDLE, run=0, err_pulse=0; err_cnt/err_sticky/wrap_cnt held.
//  err_clr with simultaneous violation: clear then count -> err_cnt=1, err_sticky=1.
//  err_cnt saturated: stays all-ones, err_pulse still fires.
//  Count skip and toggle error in same step -> single pulse, err_code=11, err_cnt +1 only.
//  Reset mid-operation: immediate return to reset values, stats lost.
// TESTING
//  1 Reset then enable, clean count 0..15 with t toggling on wrap -> locked=1 one cycle after 4th
//    good step, err_pulse never 1.
//  2 Locked, run count through 3 wraps -> wrap_cnt=3, t tracked, no errors.
//  3 Locked, inject count 5->7 -> err_pulse 1 cycle, err_code=01, err_cnt=1, locked=0,
//    relock after 4 good steps.
//  4 Locked, hold t at wrap 15->0 -> err_code=10; count skip plus bad t at 15->1 -> err_code=11,
//    err_cnt +1.
//  5 Force ERR_W=2, inject 5 errors -> err_cnt=3 saturated; err_clr same cycle as violation -> err_cnt=1.
//  6 Drop enable while locked -> locked=0 next cycle, stats held; drop rst_n mid-run ->
//    all outputs 0 immediately.

Source files
------------

// File: rtl/count_toggle_monitor.sv
// rtl/count_toggle_monitor.sv - receive-side checker for the 4-bit count/toggle interface
module count_toggle_monitor #(
   parameter int LOCK_CYCLES = 4,
   parameter int ERR_W       = 8,
   parameter int WRAP_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [3:0]        count,
   input  logic              t,
   input  logic              err_clr,
   output logic              locked,
   output logic              err_pulse,
   output logic [1:0]        err_code,
   output logic              err_sticky,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [WRAP_W-1:0] wrap_cnt
);

   typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

   state_t     state, state_n;
   logic [3:0] prev_count;
   logic       prev_t;
   logic [3:0] run, run_n;
   logic [4:0] run_inc;
   logic       skip, tog_err;
   logic       pulse_n, wrap_inc;
   logic [1:0] code_n;

   assign skip    = (count != prev_count + 4'd1);
   assign tog_err = (t != (prev_t ^ (prev_count == 4'hf)));
   assign run_inc = {1'b0, run} + 5'd1;
   assign locked  = (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         run   <= '0;
      end else begin
         state <= state_n;
         run   <= run_n;
      end
   end

   always_comb begin
      state_n  = state;
      run_n    = run;
      pulse_n  = 1'b0;
      code_n   = 2'b00;
      wrap_inc = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         run_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = SYNC;
               run_n   = '0;
            end
            SYNC: begin
               if (skip || tog_err) begin
                  run_n = '0;
               end else begin
                  run_n = run_inc[3:0];
                  if (run_inc >= 5'(LOCK_CYCLES))
                     state_n = LOCKED;
               end
            end
            LOCKED: begin
               if (skip || tog_err) begin
                  pulse_n = 1'b1;
                  code_n  = {tog_err, skip};
                  state_n = SYNC;
                  run_n   = '0;
               end else begin
                  wrap_inc = (prev_count == 4'hf);
               end
            end
            default: begin
               state_n = IDLE;
               run_n   = '0;
            end
         endcase
      end
   end

   // prev regs follow the sample whenever active, so resync starts from the latest value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_count <= '0;
         prev_t     <= 1'b0;
         err_pulse  <= 1'b0;
         err_code   <= 2'b00;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         wrap_cnt   <= '0;
      end else begin
         if (enable) begin
            prev_count <= count;
            prev_t     <= t;
         end
         err_pulse <= pulse_n;
         err_code  <= code_n;
         if (err_clr) begin
            err_cnt    <= pulse_n ? ERR_W'(1) : '0;
            err_sticky <= pulse_n;
         end else if (pulse_n) begin
            err_sticky <= 1'b1;
            if (err_cnt != '1)
               err_cnt <= err_cnt + ERR_W'(1);
         end
         if (wrap_inc)
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
   end

endmodule

// File: tb/tb_count_toggle_monitor.sv
// tb/tb_count_toggle_monitor.sv - scoreboard bench for count_toggle_monitor (ERR_W=2)
module tb_count_toggle_monitor;

   logic       clk = 1'b0;
   logic       rst_n, enable, t, err_clr;
   logic [3:0] count;
   logic       locked, err_pulse, err_sticky;
   logic [1:0] err_code;
   logic [1:0] err_cnt;
   logic [7:0] wrap_cnt;

   typedef struct {
      logic [1:0] code;
      int         cnt;
      logic       sticky;
   } exp_t;

   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_fail = 0;
   logic [3:0] cur_cnt;
   logic       cur_t;

   count_toggle_monitor #(.LOCK_CYCLES(4), .ERR_W(2), .WRAP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .count(count), .t(t),
      .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
      .err_code(err_code), .err_sticky(err_sticky), .err_cnt(err_cnt),
      .wrap_cnt(wrap_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic tt);
      count = c;
      t     = tt;
      @(negedge clk);
   endtask

   task automatic good(input int n);
      for (int i = 0; i < n; i++) begin
         if (cur_cnt == 4'hf) cur_t = ~cur_t;
         cur_cnt = cur_cnt + 4'd1;
         drive(cur_cnt, cur_t);
      end
   endtask

   task automatic bad(input logic [3:0] c, input logic tt, input logic [1:0] code,
                      input int cnt, input logic sticky);
      exp_t e;
      e.code = code;
      e.cnt = cnt;
      e.sticky = sticky;
      sb.push_back(e);
      cur_cnt = c;
      cur_t = tt;
      drive(c, tt);
   endtask

   // monitor: each err_pulse consumes one expected violation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && err_pulse === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_err_pulse", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("err_code", int'(err_code), int'(e.code));
            chk("err_cnt", int'(err_cnt), e.cnt);
            chk("err_sticky", int'(err_sticky), int'(e.sticky));
            chk("locked_on_err", int'(locked), 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; count = 4'd0; t = 1'b0;
      cur_cnt = 4'd0; cur_t = 1'b0;
      @(negedge clk);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_pulse", int'(err_pulse), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_err_sticky", int'(err_sticky), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_wrap_cnt", int'(wrap_cnt), 0);
      rst_n = 1'b1;
      enable = 1'b1;

      // clean sequence, lock after the 4th good step
      drive(cur_cnt, cur_t);
      good(3);
      chk("locked_after_3", int'(locked), 0);
      good(1);
      chk("locked_after_4", int'(locked), 1);
      good(11);
      chk("wrap_before", int'(wrap_cnt), 0);

      // three wraps while locked
      good(48);
      chk("wrap_3", int'(wrap_cnt), 3);
      chk("locked_wraps", int'(locked), 1);
      good(6);
      chk("wrap_4", int'(wrap_cnt), 4);

      // count skip 5->7 and relock
      bad(4'd7, cur_t, 2'b01, 1, 1'b1);
      good(3);
      chk("relock_3", int'(locked), 0);
      good(1);
      chk("relock_4", int'(locked), 1);

      // t held at wrap, then skip plus bad t (saturates at 3)
      good(4);
      bad(4'd0, cur_t, 2'b10, 2, 1'b1);
      good(4);
      chk("relock_b", int'(locked), 1);
      good(11);
      bad(4'd1, cur_t, 2'b11, 3, 1'b1);
      good(4);
      bad(4'd7, cur_t, 2'b01, 3, 1'b1);
      good(4);
      bad(4'd13, cur_t, 2'b01, 3, 1'b1);
      good(4);
      chk("relock_c", int'(locked), 1);

      // clear coincident with a violation, then a plain clear
      err_clr = 1'b1;
      bad(4'd3, cur_t, 2'b01, 1, 1'b1);
      err_clr = 1'b0;
      good(4);
      err_clr = 1'b1;
      good(1);
      err_clr = 1'b0;
      chk("clr_err_cnt", int'(err_cnt), 0);
      chk("clr_sticky", int'(err_sticky), 0);
      chk("clr_locked", int'(locked), 1);
      chk("wrap_held_4", int'(wrap_cnt), 4);

      // drop enable while locked
      enable = 1'b0;
      good(1);
      chk("dis_locked", int'(locked), 0);
      chk("dis_wrap", int'(wrap_cnt), 4);
      chk("dis_pulse", int'(err_pulse), 0);
      good(2);
      chk("dis_locked2", int'(locked), 0);
      enable = 1'b1;
      good(1);
      good(4);
      chk("reen_locked", int'(locked), 1);
      chk("sb_empty", sb.size(), 0);

      // asynchronous reset mid-run
      #2 rst_n = 1'b0;
      #1;
      chk("arst_locked", int'(locked), 0);
      chk("arst_wrap", int'(wrap_cnt), 0);
      chk("arst_pulse", int'(err_pulse), 0);
      chk("arst_code", int'(err_code), 0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
